// File: rtl/acc_feed.sv
// acc_feed: MSB-first serial driver for the acc accumulator interface (tx/add/clear).
// Define ACC_FEED_BUF_EN to add a one-entry holding buffer for back-to-back frames.
module acc_feed #(
  parameter int WIDTH = 33,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clr_req,
  output logic             ready,
  output logic             clr_ack,
  output logic             busy,
  output logic             done,
  output logic             tx,
  output logic             add,
  output logic             clear
);

  localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GCNT_W  = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_CLR
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shreg_nx;
  logic [CNT_W-1:0]  cnt;
  logic [GCNT_W-1:0] gcnt;
  logic              launch;
  logic [WIDTH-1:0]  launch_word;

  assign shreg_nx = shreg << 1;

`ifdef ACC_FEED_BUF_EN
  logic             buf_valid;
  logic [WIDTH-1:0] buf_data;

  assign ready = (state == ST_IDLE || state == ST_SEND || state == ST_GAP)
                 && !buf_valid && !clr_req;

  // Words accepted mid-frame park here until the current frame's gap ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (load && ready && state != ST_IDLE) begin
      buf_valid <= 1'b1;
      buf_data  <= data_in;
    end else if (launch && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign ready = (state == ST_IDLE) && !clr_req;
`endif

  // A buffered word wins over a pending clear so clears never split queued data.
  always_comb begin
    launch      = 1'b0;
    launch_word = data_in;
    if (state == ST_IDLE && load && ready) begin
      launch = 1'b1;
    end
`ifdef ACC_FEED_BUF_EN
    if (buf_valid && (state == ST_IDLE || (state == ST_GAP && gcnt == '0))) begin
      launch      = 1'b1;
      launch_word = buf_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      tx      <= 1'b0;
      add     <= 1'b0;
      clear   <= 1'b0;
      clr_ack <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        shreg <= launch_word;
        tx    <= launch_word[WIDTH-1];
        add   <= 1'b1;
        cnt   <= CNT_LAST;
        busy  <= 1'b1;
        state <= ST_SEND;
      end else begin
        case (state)
          ST_IDLE: begin
            if (clr_req) begin
              clear   <= 1'b1;
              clr_ack <= 1'b1;
              state   <= ST_CLR;
            end
          end
          ST_SEND: begin
            if (cnt == '0) begin
              add   <= 1'b0;
              tx    <= 1'b0;
              done  <= 1'b1;
              gcnt  <= GCNT_LAST;
              state <= ST_GAP;
            end else begin
              shreg <= shreg_nx;
              tx    <= shreg_nx[WIDTH-1];
              cnt   <= cnt - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (gcnt == '0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              gcnt <= gcnt - GCNT_W'(1);
            end
          end
          ST_CLR: begin
            clear   <= 1'b0;
            clr_ack <= 1'b0;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
